sm_mem_responder: RTL
=====================

Name: sm_mem_responder

Overview:
- Memory-side responder for the serial matmul accelerator's memory request/response interface.
- Accepts read/write requests of 40b address and 64b data, services them from an internal word array, and returns in-order responses after a fixed latency.
- Responses pass through a bounded response queue with val/rdy backpressure.
- Serves as the memory model for accelerator-level simulation and as a standalone scratchpad.

Parameters:
- ENTRIES, 256, number of 64b words in storage (power of 2).
- LATENCY, 2, cycles from request acceptance to earliest response valid (>=1).
- QDEPTH, 4, maximum outstanding requests, counted as in pipeline plus in response queue (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- mem_req_val_i  input  1  request valid
- mem_req_rdy_o  output  1  request ready
- mem_req_cmd_i  input  1  0=read, 1=write
- mem_req_addr_i  input  40  byte address
- mem_req_data_i  input  64  write data
- mem_resp_val_o  output  1  response valid
- mem_resp_rdy_i  input  1  response ready
- mem_resp_cmd_o  output  1  echoed cmd
- mem_resp_addr_o  output  40  echoed address
- mem_resp_data_o  output  64  read data (reads) / written data (writes)
- mem_resp_err_o  output  1  address error flag

Behaviour:
- Reset is synchronous and active-low: reset==0 sampled at posedge clears the pipeline valids, queue pointers and the outstanding counter.
- Storage contents are not cleared by reset.
- While reset==0: mem_req_rdy_o=0, mem_resp_val_o=0, and mem_resp_cmd/addr/data/err are all 0.
- Request handshake:
  - A request fires when mem_req_val_i && mem_req_rdy_o at posedge.
  - mem_req_rdy_o = (outstanding < QDEPTH). It is computed from the registered counter only, with no same-cycle bypass from a response fire.
- Address decode:
  - Word index = addr[3 +: log2(ENTRIES)].
  - Error when addr[2:0]!=0 or addr >= ENTRIES*8.
- Access timing:
  - A write updates storage at the fire edge unless in error.
  - A read samples storage at the fire edge. A read fired on the cycle after a write to the same word returns the new data.
  - Error reads return data 0. Error writes leave storage unchanged.
  - Both cases set err=1 in the response.
- Pipeline:
  - A request fired at edge t enters a LATENCY-deep shift pipeline of {cmd, addr, data, err}.
  - It enters the response queue at edge t+LATENCY-1, so mem_resp_val_o can first be high in the cycle after edge t+LATENCY-1 (LATENCY cycles after fire).
  - The pipeline always advances; the outstanding-credit rule guarantees queue space.
- Response queue:
  - FIFO of depth QDEPTH.
  - The head drives the mem_resp_* outputs; mem_resp_val_o = queue not empty.
  - Pop occurs on mem_resp_val_o && mem_resp_rdy_i.
  - Push and pop in the same cycle are both performed. Push into an empty queue does not bypass to the outputs in the same cycle.
- Outstanding counter:
  - +1 on request fire, -1 on response fire, unchanged when both happen.
  - Never exceeds QDEPTH and never underflows.
- Ordering: responses are strictly in request order, with no reordering or merging.
- Reset mid-operation: all in-flight and queued responses are discarded, and no response is emitted for them afterwards. Writes that already fired remain in storage.
- Outputs are held stable while mem_resp_val_o=1 and mem_resp_rdy_i=0.

Optional Feature:
- Macro SM_MEM_RESPONDER_BYTEMASK_EN.
- Defined:
  - Adds input port mem_req_wmask_i [7:0]. Write updates only the bytes whose mask bit is 1 (bit k covers data[8k+7:8k]).
  - Write response data = the resulting full stored word.
  - The mask is ignored for reads.
- Undefined:
  - No mask port; writes update all 8 bytes.
  - Write response data = mem_req_data_i.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with req_val=1 -> req_rdy=0, resp_val=0, all resp outputs 0; after reset=1, req_rdy=1 and storage unchanged.
- Write/read: write 0xDEADBEEF_01234567 to addr 0x10, then read 0x10 on the next cycle, resp_rdy=1 -> write resp appears 2 cycles after fire with err=0; read resp data 0xDEADBEEF_01234567, addr 0x10, cmd=0.
- Backpressure: resp_rdy=0, issue 6 back-to-back reads with QDEPTH=4 -> exactly 4 fire and req_rdy=0 after the 4th; raise resp_rdy -> 4 responses in order, then req_rdy returns 1.
- Simultaneous: at outstanding=QDEPTH, pop a response and offer a request in the same cycle -> request not accepted that cycle and accepted the next; counter stays consistent.
- Errors: read addr 0x13 and read addr ENTRIES*8 -> both return err=1, data 0. Write to 0x13 -> err=1 and a later read of 0x10 is unchanged.
- Reset mid-op: 3 requests in flight, pull reset=0 for 1 cycle -> no responses ever appear; a subsequent read of a location written before reset returns the written value.
- (Only with SM_MEM_RESPONDER_BYTEMASK_EN) Mask: write 0xFFFF...FF with mask 0x0F over 0 -> stored/returned 0x00000000_FFFFFFFF.

Source files
------------

// File: rtl/sm_mem_responder.sv
// Memory-side responder: word storage, fixed-latency pipeline and in-order response queue.
// Optional byte-masked writes are enabled with `define SM_MEM_RESPONDER_BYTEMASK_EN.
module sm_mem_responder #(
   parameter int ENTRIES = 256,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req_val_i,
   output logic        mem_req_rdy_o,
   input  logic        mem_req_cmd_i,
   input  logic [39:0] mem_req_addr_i,
   input  logic [63:0] mem_req_data_i,
`ifdef SM_MEM_RESPONDER_BYTEMASK_EN
   input  logic [7:0]  mem_req_wmask_i,
`endif
   output logic        mem_resp_val_o,
   input  logic        mem_resp_rdy_i,
   output logic        mem_resp_cmd_o,
   output logic [39:0] mem_resp_addr_o,
   output logic [63:0] mem_resp_data_o,
   output logic        mem_resp_err_o
);

   localparam int AW = $clog2(ENTRIES);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

   typedef struct packed {
      logic        cmd;
      logic [39:0] addr;
      logic [63:0] data;
      logic        err;
   } entry_t;

   // Read: storage word (0 on error). Write: the word as it ends up stored, or the raw data on error.
   function automatic logic [63:0] resolve_data(input logic cmd, input logic err,
                                                input logic [63:0] wdata, input logic [7:0] wmask,
                                                input logic [63:0] old);
      logic [63:0] res;
      if (!cmd) begin
         res = err ? 64'h0 : old;
      end else if (err) begin
         res = wdata;
      end else begin
         for (int k = 0; k < 8; k++) begin
            res[8*k +: 8] = wmask[k] ? wdata[8*k +: 8] : old[8*k +: 8];
         end
      end
      return res;
   endfunction

   logic [7:0]    req_wmask;
   logic          req_fire;
   logic          req_err;
   logic [AW-1:0] req_idx;
   logic          push_val;
   entry_t        push_entry;
   logic          resp_val;
   logic          resp_pop;
   entry_t        head;

   logic [63:0]   mem_q [ENTRIES];
   entry_t        qmem_q [QDEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;

`ifdef SM_MEM_RESPONDER_BYTEMASK_EN
   assign req_wmask = mem_req_wmask_i;
`else
   assign req_wmask = 8'hFF;
`endif

   assign mem_req_rdy_o = reset && (outst_q < QDEPTH_C);
   assign req_fire      = mem_req_val_i && mem_req_rdy_o;
   assign req_idx       = mem_req_addr_i[3 +: AW];
   assign req_err       = (mem_req_addr_i[2:0] != 3'b000) || (mem_req_addr_i[39:AW+3] != '0);

   always_ff @(posedge clk) begin
      if (req_fire && mem_req_cmd_i && !req_err) begin
         for (int k = 0; k < 8; k++) begin
            if (req_wmask[k]) begin
               mem_q[req_idx][8*k +: 8] <= mem_req_data_i[8*k +: 8];
            end
         end
      end
   end

   generate
      if (LATENCY == 1) begin : g_lat1
         // Queue push coincides with the fire edge, so the old word is read combinationally.
         always_comb begin
            push_val   = req_fire;
            push_entry = '{cmd:  mem_req_cmd_i,
                           addr: mem_req_addr_i,
                           data: resolve_data(mem_req_cmd_i, req_err, mem_req_data_i,
                                              req_wmask, mem_q[req_idx]),
                           err:  req_err};
         end
      end else begin : g_latn
         logic        s0_val_q;
         entry_t      s0_q;
         logic [7:0]  s0_wmask_q;
         logic [63:0] s0_old_q;
         entry_t      s0_res;

         always_ff @(posedge clk) begin
            if (!reset) begin
               s0_val_q <= 1'b0;
            end else begin
               s0_val_q <= req_fire;
            end
            s0_q       <= '{cmd: mem_req_cmd_i, addr: mem_req_addr_i,
                            data: mem_req_data_i, err: req_err};
            s0_wmask_q <= req_wmask;
            s0_old_q   <= mem_q[req_idx];
         end

         always_comb begin
            s0_res      = s0_q;
            s0_res.data = resolve_data(s0_q.cmd, s0_q.err, s0_q.data, s0_wmask_q, s0_old_q);
         end

         if (LATENCY == 2) begin : g_direct
            assign push_val   = s0_val_q;
            assign push_entry = s0_res;
         end else begin : g_stages
            logic   stg_val_q [LATENCY-2];
            entry_t stg_q     [LATENCY-2];

            always_ff @(posedge clk) begin
               if (!reset) begin
                  for (int k = 0; k < LATENCY-2; k++) begin
                     stg_val_q[k] <= 1'b0;
                  end
               end else begin
                  stg_val_q[0] <= s0_val_q;
                  for (int k = 1; k < LATENCY-2; k++) begin
                     stg_val_q[k] <= stg_val_q[k-1];
                  end
               end
               stg_q[0] <= s0_res;
               for (int k = 1; k < LATENCY-2; k++) begin
                  stg_q[k] <= stg_q[k-1];
               end
            end

            assign push_val   = stg_val_q[LATENCY-3];
            assign push_entry = stg_q[LATENCY-3];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push_val) begin
         qmem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign head     = qmem_q[rd_ptr_q];
   assign resp_val = reset && (count_q != '0);
   assign resp_pop = resp_val && mem_resp_rdy_i;

   assign mem_resp_val_o  = resp_val;
   assign mem_resp_cmd_o  = resp_val && head.cmd;
   assign mem_resp_addr_o = resp_val ? head.addr : 40'h0;
   assign mem_resp_data_o = resp_val ? head.data : 64'h0;
   assign mem_resp_err_o  = resp_val && head.err;

   // Outstanding credit covers pipeline plus queue, so a push never finds the queue full.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      outst_d  = outst_q;
      if (push_val) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (resp_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_val && !resp_pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_val && resp_pop) begin
         count_d = count_q - 1'b1;
      end
      if (req_fire && !resp_pop) begin
         outst_d = outst_q + 1'b1;
      end else if (!req_fire && resp_pop) begin
         outst_d = outst_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         outst_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         outst_q  <= outst_d;
      end
   end

endmodule
